stereo_disparity_stream: RTL
============================

// Module: stereo_disparity_stream
// PURPOSE
//  Streaming successor to the frame-buffered depth-map reader: consumes a raster stream of left/right grey pixel pairs.
//  Emits one disparity value per input pixel, using a horizontal WIN-wide cost window and a sequential search over 0..MAX_DISP.
//  Sits between the image source (hex-file reader / sensor) and the depth-map writer.
//  No full-frame storage; only per-row shift buffers.
// PARAMETERS
//  WIDTH     320  pixels per row
//  HEIGHT    240  rows per frame
//  PW        8    pixel bit width
//  WIN       7    window width (odd, >=3)
//  MAX_DISP  15   largest disparity searched (candidates 0..MAX_DISP)
//  SCALE     17   out_depth = best_d*SCALE, saturated to 2^PW-1
// PORTS
//  HCLK        in   1   clock
//  HRESET      in   1   synchronous reset, active-high
//  in_valid    in   1   pixel pair valid
//  in_ready    out  1   block accepts pixel pair
//  in_left     in   PW  left pixel
//  in_right    in   PW  right pixel
//  out_valid   out  1   result valid
//  out_ready   in   1   downstream accepts result
//  out_disp    out  $clog2(MAX_DISP+1)  best disparity
//  out_depth   out  PW  scaled disparity (grey depth)
//  out_hsync   out  1   high with out_valid on last pixel of a row
//  frame_done  out  1   one-cycle pulse after last pixel of frame is consumed downstream
// BEHAVIOUR
//  Reset: all outputs 0; col=row=0; line buffers cleared; FSM=ACCEPT (in_ready=1 from first cycle after reset release).
//  Reset mid-operation: aborts search, drops pending result, restarts at col=row=0.
//  FSM: ACCEPT -> SEARCH -> OUTPUT -> ACCEPT.
//   ACCEPT: in_ready=1. On in_valid, shift in_left into L buffer (WIN deep) and in_right into R buffer (WIN+MAX_DISP deep).
//           Latch col; set d=0, best_cost=all-ones, best_d=0. Go to SEARCH.
//   SEARCH: one candidate per cycle; cost(d) = sum over k=0..WIN-1 of diff(L[col-k], R[col-k-d]).
//           Candidate valid only if col-WIN+1-d >= 0. Invalid candidates are skipped (no update).
//           Update when cost < best_cost (strict; ties keep smaller d).
//           After d==MAX_DISP, go to OUTPUT; SEARCH lasts exactly MAX_DISP+1 cycles.
//           If col < WIN-1, no candidate is valid and the result is disp 0.
//   OUTPUT: out_valid=1, outputs held stable until out_ready.
//           On out_valid&&out_ready: col wraps WIDTH-1->0 (row++, buffers cleared); row wraps HEIGHT-1->0 with frame_done pulse.
//  Latency in_valid accept -> out_valid: MAX_DISP+2 cycles. Throughput: 1 pixel per MAX_DISP+3 cycles with out_ready=1.
//  Arithmetic: diff unsigned, width COST_W = 2*PW+$clog2(WIN)+1; best_cost init all-ones (never overflows).
//  out_depth = min(best_d*SCALE, 2^PW-1).
//  in_ready=0 in SEARCH and OUTPUT; in_valid is ignored there (source holds data).
// CONFIGURATION
//  COST_SAD_EN defined: diff = |a-b| (sum of absolute differences).
//  COST_SAD_EN not defined: diff = (a-b)^2 (sum of squared differences, default).
//  Port list and timing identical in both builds.
// STRUCTURE
//  Package stereo_pkg: FSM state enum (ST_ACCEPT, ST_SEARCH, ST_OUTPUT), COST_W/DISP_W functions, cost-mode constant.
//  Sub-module window_cost: combinational WIN-tap cost of L buffer vs R buffer slice at offset d (SAD/SSD per macro).
//  Top holds buffers, FSM, counters, argmin.
// TESTING
//  1. WIDTH=16, HEIGHT=2: right = left shifted by 3 (ramp texture) -> out_disp=3 for every col>=WIN-1+3, out_depth=51.
//  2. Identical L/R images -> all out_disp=0 (tie rule keeps d=0); cols 0..WIN-2 -> 0.
//  3. Flat grey (all 128) both images -> all costs equal -> out_disp=0; frame_done pulses once after 32nd output.
//  4. Hold out_ready=0 for 20 cycles in OUTPUT -> out_valid/out_disp stable, in_ready=0; resume with no lost/duplicate pixel.
//  5. Assert HRESET in SEARCH -> next cycle outputs 0, in_ready=1; following frame yields results identical to test 1.
//  6. Build with COST_SAD_EN, single outlier pixel +100 -> disparity unaffected vs SSD where outlier dominates; check cost widths.
//  Checks: out_hsync on col==WIDTH-1 only; latency exactly MAX_DISP+2; argmin matches reference model bit-exactly.

Source files
------------

// File: rtl/stereo_pkg.sv
// stereo_pkg: shared FSM state type, width helpers and cost-mode selection
// for the streaming stereo disparity block.
// Build option: define COST_SAD_EN for sum of absolute differences;
// leave it undefined for sum of squared differences.
package stereo_pkg;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_SEARCH = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  // Accumulator width: one squared pixel difference is 2*pw bits and WIN of
  // them add $clog2(win) bits; the extra bit keeps all-ones above any real cost.
  function automatic int cost_w(input int pw, input int win);
    return 2 * pw + $clog2(win) + 1;
  endfunction

  function automatic int disp_w(input int max_disp);
    return (max_disp < 1) ? 1 : $clog2(max_disp + 1);
  endfunction

`ifdef COST_SAD_EN
  localparam bit COST_SAD = 1'b1;
`else
  localparam bit COST_SAD = 1'b0;
`endif

endpackage

// File: rtl/stereo_disparity_stream_window_cost.sv
// window_cost: combinational WIN-tap matching cost between the left window
// and the right buffer slice starting at candidate disparity d.
// Cost kind follows stereo_pkg::COST_SAD (set by the COST_SAD_EN macro).
module window_cost
  import stereo_pkg::*;
#(
  parameter  int PW       = 8,
  parameter  int WIN      = 7,
  parameter  int MAX_DISP = 15,
  localparam int DW       = disp_w(MAX_DISP),
  localparam int CW       = cost_w(PW, WIN),
  localparam int RD       = WIN + MAX_DISP
) (
  input  logic [WIN-1:0][PW-1:0] l_win,
  input  logic [RD-1:0][PW-1:0]  r_win,
  input  logic [DW-1:0]          d,
  output logic [CW-1:0]          cost
);

  logic [PW-1:0]   a_px;
  logic [PW-1:0]   b_px;
  logic [PW-1:0]   ad;
  logic [2*PW-1:0] term;

  // Tap k pairs the left pixel k columns back with the right pixel k+d back.
  always_comb begin
    cost = '0;
    a_px = '0;
    b_px = '0;
    ad   = '0;
    term = '0;
    for (int k = 0; k < WIN; k++) begin
      a_px = l_win[k];
      b_px = r_win[k + int'(d)];
      ad   = (a_px > b_px) ? (a_px - b_px) : (b_px - a_px);
      if (COST_SAD) term = {{PW{1'b0}}, ad};
      else          term = {{PW{1'b0}}, ad} * {{PW{1'b0}}, ad};
      cost = cost + CW'(term);
    end
  end

endmodule

// File: rtl/stereo_disparity_stream.sv
// stereo_disparity_stream: per-pixel disparity from a raster stream of
// left/right pixel pairs using a horizontal window and a sequential search.
// Build option: COST_SAD_EN selects SAD instead of the default SSD cost.
//
//  state     | meaning
//  ST_ACCEPT | in_ready=1, wait for a pixel pair, shift it into the buffers
//  ST_SEARCH | evaluate one candidate disparity per cycle, 0..MAX_DISP
//  ST_OUTPUT | present result, hold until out_ready
module stereo_disparity_stream
  import stereo_pkg::*;
#(
  parameter  int WIDTH    = 320,
  parameter  int HEIGHT   = 240,
  parameter  int PW       = 8,
  parameter  int WIN      = 7,
  parameter  int MAX_DISP = 15,
  parameter  int SCALE    = 17,
  localparam int DW       = disp_w(MAX_DISP),
  localparam int CW       = cost_w(PW, WIN),
  localparam int RD       = WIN + MAX_DISP,
  localparam int XW       = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int YW       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_left,
  input  logic [PW-1:0] in_right,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_disp,
  output logic [PW-1:0] out_depth,
  output logic          out_hsync,
  output logic          frame_done
);

  localparam int PMAX = (1 << PW) - 1;

  state_t                 state_q, state_d;
  logic [WIN-1:0][PW-1:0] l_buf_q, l_buf_d;
  logic [RD-1:0][PW-1:0]  r_buf_q, r_buf_d;
  logic [XW-1:0]          col_q, col_d;
  logic [YW-1:0]          row_q, row_d;
  logic [DW-1:0]          cand_q, cand_d;
  logic [CW-1:0]          best_cost_q, best_cost_d;
  logic [DW-1:0]          best_d_q, best_d_d;
  logic                   frame_done_q, frame_done_d;

  logic [CW-1:0]          cost;
  logic                   cand_valid;
  int                     depth_full;
  logic [PW-1:0]          depth;

  window_cost #(.PW(PW), .WIN(WIN), .MAX_DISP(MAX_DISP)) u_cost (
    .l_win (l_buf_q),
    .r_win (r_buf_q),
    .d     (cand_q),
    .cost  (cost)
  );

  // Candidate d needs all WIN right-image taps inside the current row.
  assign cand_valid = (int'(col_q) >= WIN - 1 + int'(cand_q));

  // Next-state, buffer shift, argmin and raster counters.
  always_comb begin
    state_d      = state_q;
    l_buf_d      = l_buf_q;
    r_buf_d      = r_buf_q;
    col_d        = col_q;
    row_d        = row_q;
    cand_d       = cand_q;
    best_cost_d  = best_cost_q;
    best_d_d     = best_d_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_ACCEPT: begin
        if (in_valid) begin
          l_buf_d     = {l_buf_q[WIN-2:0], in_left};
          r_buf_d     = {r_buf_q[RD-2:0], in_right};
          cand_d      = '0;
          best_cost_d = '1;
          best_d_d    = '0;
          state_d     = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        // Strict compare: on a tie the smaller disparity already stored wins.
        if (cand_valid && (cost < best_cost_q)) begin
          best_cost_d = cost;
          best_d_d    = cand_q;
        end
        if (cand_q == DW'(MAX_DISP)) state_d = ST_OUTPUT;
        else                         cand_d  = cand_q + 1'b1;
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          state_d = ST_ACCEPT;
          if (col_q == XW'(WIDTH - 1)) begin
            col_d   = '0;
            l_buf_d = '0;
            r_buf_d = '0;
            if (row_q == YW'(HEIGHT - 1)) begin
              row_d        = '0;
              frame_done_d = 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= ST_ACCEPT;
      l_buf_q      <= '0;
      r_buf_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
      cand_q       <= '0;
      best_cost_q  <= '1;
      best_d_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      l_buf_q      <= l_buf_d;
      r_buf_q      <= r_buf_d;
      col_q        <= col_d;
      row_q        <= row_d;
      cand_q       <= cand_d;
      best_cost_q  <= best_cost_d;
      best_d_q     <= best_d_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Grey depth: disparity scaled and saturated to the pixel range.
  always_comb begin
    depth_full = int'(best_d_q) * SCALE;
    depth      = (depth_full > PMAX) ? PW'(PMAX) : PW'(depth_full);
  end

  assign in_ready   = (state_q == ST_ACCEPT);
  assign out_valid  = (state_q == ST_OUTPUT);
  assign out_disp   = out_valid ? best_d_q : '0;
  assign out_depth  = out_valid ? depth : '0;
  assign out_hsync  = out_valid && (col_q == XW'(WIDTH - 1));
  assign frame_done = frame_done_q;

endmodule
